// File: rtl/cmd_bus_bridge_if.sv
// cmd_bus_bridge_if: host byte-FIFO and register-interconnect signals of cmd_bus_bridge
interface cmd_bus_bridge_if;
  logic [7:0] i_fifo_data;
  logic i_fifo_empty;
  logic i_fifo_almost_empty;
  logic o_fifo_read_enable;
  logic [7:0] o_fifo_data;
  logic i_fifo_full;
  logic o_fifo_write_enable;
  logic o_addr_valid;
  logic o_write_enable;
  logic o_write_data_valid;
  logic i_addr_ready;
  logic i_write_data_ready;
  logic i_read_data_valid;
  logic o_read_data_ready;
  logic [31:0] o_common;
  logic [31:0] i_read_data;
  modport master(
    input i_fifo_data, i_fifo_empty, i_fifo_almost_empty, i_fifo_full,
    input i_addr_ready, i_write_data_ready, i_read_data_valid, i_read_data,
    output o_fifo_read_enable, o_fifo_data, o_fifo_write_enable,
    output o_addr_valid, o_write_enable, o_write_data_valid, o_read_data_ready, o_common
  );
  modport slave(
    output i_fifo_data, i_fifo_empty, i_fifo_almost_empty, i_fifo_full,
    output i_addr_ready, i_write_data_ready, i_read_data_valid, i_read_data,
    input o_fifo_read_enable, o_fifo_data, o_fifo_write_enable,
    input o_addr_valid, o_write_enable, o_write_data_valid, o_read_data_ready, o_common
  );
endinterface

// File: rtl/cmd_bus_bridge.sv
// cmd_bus_bridge: byte-FIFO command stream to 32-bit valid/ready register bus bridge.
// Define CMDCTRL_WRITE_ACK_EN to push an 8'hA5 acknowledge byte after every write.
module cmd_bus_bridge #(
  parameter int WORD_WIDTH = 32,
  parameter logic [7:0] CMD_READ = 8'h01,
  parameter logic [7:0] CMD_WRITE = 8'h02
) (
  input logic clk,
  input logic reset_n,
  cmd_bus_bridge_if.master bus
);
  typedef enum logic [2:0] {
    IDLE, GET_ADDR, ADDR_PHASE, GET_WDATA, WDATA_PHASE, RDATA_PHASE, PUSH_RDATA
`ifdef CMDCTRL_WRITE_ACK_EN
    , ACK
`endif
  } state_t;
  state_t state, state_d;
  logic [WORD_WIDTH-1:0] sh, common;
  logic [2:0] cnt, need;
  logic pend, is_wr, collecting, getting, pop, last, push;
  assign need = state == IDLE ? 3'd1 : 3'd4;
  assign getting = state == GET_ADDR || state == GET_WDATA;
  assign collecting = state == IDLE || getting;
  // pend marks a pop whose byte arrives this cycle; it counts as issued so we never over-pop
  assign pop = collecting && (cnt + {2'b0, pend}) < need && !bus.i_fifo_empty &&
               (!pend || !bus.i_fifo_almost_empty);
  assign last = getting && pend && cnt == 3'd3;
`ifdef CMDCTRL_WRITE_ACK_EN
  assign push = (state == PUSH_RDATA || state == ACK) && !bus.i_fifo_full;
  assign bus.o_fifo_data = state == ACK ? 8'hA5 : sh[WORD_WIDTH-1 -: 8];
`else
  assign push = state == PUSH_RDATA && !bus.i_fifo_full;
  assign bus.o_fifo_data = sh[WORD_WIDTH-1 -: 8];
`endif
  assign bus.o_fifo_read_enable = pop && reset_n;
  assign bus.o_fifo_write_enable = push;
  assign bus.o_addr_valid = state == ADDR_PHASE;
  assign bus.o_write_enable = is_wr && state != IDLE;
  assign bus.o_write_data_valid = state == WDATA_PHASE;
  assign bus.o_read_data_ready = state == RDATA_PHASE;
  assign bus.o_common = common;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) state <= IDLE;
    else state <= state_d;
  always_comb begin
    state_d = state;
    case (state)
      IDLE: if (pend && (bus.i_fifo_data == CMD_READ || bus.i_fifo_data == CMD_WRITE)) state_d = GET_ADDR;
      GET_ADDR: if (last) state_d = ADDR_PHASE;
      ADDR_PHASE: if (bus.i_addr_ready) state_d = is_wr ? GET_WDATA : RDATA_PHASE;
      GET_WDATA: if (last) state_d = WDATA_PHASE;
`ifdef CMDCTRL_WRITE_ACK_EN
      WDATA_PHASE: if (bus.i_write_data_ready) state_d = ACK;
      ACK: if (push) state_d = IDLE;
`else
      WDATA_PHASE: if (bus.i_write_data_ready) state_d = IDLE;
`endif
      RDATA_PHASE: if (bus.i_read_data_valid) state_d = PUSH_RDATA;
      PUSH_RDATA: if (push && cnt == 3'd3) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  // sh assembles incoming address/data bytes and serialises read data; common only moves at phase entry
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      pend <= 1'b0;
      cnt <= 3'd0;
      is_wr <= 1'b0;
      sh <= '0;
      common <= '0;
    end else begin
      pend <= pop;
      if (state == IDLE && pend) is_wr <= bus.i_fifo_data == CMD_WRITE;
      if (getting && pend) begin
        sh <= {sh[WORD_WIDTH-9:0], bus.i_fifo_data};
        cnt <= last ? 3'd0 : cnt + 3'd1;
      end
      if (last) common <= {sh[WORD_WIDTH-9:0], bus.i_fifo_data};
      if (state == RDATA_PHASE && bus.i_read_data_valid) sh <= bus.i_read_data;
      if (state == PUSH_RDATA && push) begin
        sh <= sh << 8;
        cnt <= cnt == 3'd3 ? 3'd0 : cnt + 3'd1;
      end
    end
endmodule

// File: tb/tb_cmd_bus_bridge.sv
// tb_cmd_bus_bridge: directed vectors for cmd_bus_bridge with RX/TX FIFO and bus slave models
module tb_cmd_bus_bridge;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;
  cmd_bus_bridge_if bus();
  cmd_bus_bridge dut(.clk(clk), .reset_n(reset_n), .bus(bus));
  int n_tests = 0, n_fail = 0;
  logic [7:0] rx_mem[$];
  logic [7:0] txq[$];
  logic [32:0] alog[$];
  logic [31:0] wlog[$];
  int rx_avail = 0, rx_rd = 0, pops = 0, underflow = 0, overflow = 0;
  int addr_hold = 0, wdata_hold = 0, rd_delay = 0;
  int a_cnt = 0, w_cnt = 0, r_cnt = 0, a_cyc = 0, w_cyc = 0, we_cyc = 0, viol = 0;
  logic rd_pend = 1'b0, a_hold = 1'b0, w_hold = 1'b0;
  logic [31:0] held_common = '0, rdata = '0;
  assign bus.i_fifo_empty = rx_avail == rx_rd;
  assign bus.i_fifo_almost_empty = rx_avail - rx_rd <= 1;
  // registered-read RX FIFO: byte appears the cycle after the pop
  always @(posedge clk)
    if (bus.o_fifo_read_enable) begin
      if (rx_rd >= rx_avail) underflow <= underflow + 1;
      bus.i_fifo_data <= rx_rd < rx_mem.size() ? rx_mem[rx_rd] : 8'h00;
      rx_rd <= rx_rd + 1;
      pops <= pops + 1;
    end
  always @(posedge clk)
    if (bus.o_fifo_write_enable) begin
      if (bus.i_fifo_full) overflow <= overflow + 1;
      else txq.push_back(bus.o_fifo_data);
    end
  // bus slave: decides ready/valid mid-cycle and logs the handshakes the next edge completes
  always @(negedge clk) begin
    if (a_hold && (!bus.o_addr_valid || bus.o_common != held_common)) viol++;
    if (w_hold && (!bus.o_write_data_valid || bus.o_common != held_common)) viol++;
    bus.i_addr_ready = a_cnt >= addr_hold;
    bus.i_write_data_ready = w_cnt >= wdata_hold;
    bus.i_read_data_valid = rd_pend && r_cnt >= rd_delay;
    bus.i_read_data = rdata;
    a_hold = bus.o_addr_valid && !bus.i_addr_ready;
    w_hold = bus.o_write_data_valid && !bus.i_write_data_ready;
    held_common = bus.o_common;
    if (bus.o_addr_valid) a_cyc++;
    if (bus.o_write_data_valid) w_cyc++;
    if (bus.o_write_enable) we_cyc++;
    a_cnt = a_hold ? a_cnt + 1 : 0;
    w_cnt = w_hold ? w_cnt + 1 : 0;
    if (rd_pend) r_cnt++;
    if (bus.i_read_data_valid && bus.o_read_data_ready) rd_pend = 1'b0;
    if (bus.o_addr_valid && bus.i_addr_ready) begin
      alog.push_back({bus.o_write_enable, bus.o_common});
      if (!bus.o_write_enable) begin
        rd_pend = 1'b1;
        r_cnt = 0;
      end
    end
    if (bus.o_write_data_valid && bus.i_write_data_ready) wlog.push_back(bus.o_common);
  end
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic run(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic feed(input logic [71:0] bytes, input int n, input int gap);
    for (int i = 0; i < n; i++) begin
      rx_mem.push_back(bytes[8*(n-1-i) +: 8]);
      rx_avail++;
      if (gap > 0) run(gap);
    end
  endtask
  task automatic wait_tx(input int target);
    int k = 0;
    while (txq.size() < target && k < 60) begin
      @(negedge clk);
      k++;
    end
    chk("wait_tx", 64'(txq.size() >= target), 64'd1);
  endtask
  function automatic logic [63:0] outs();
    return {18'd0, bus.o_fifo_read_enable, bus.o_fifo_write_enable, bus.o_addr_valid,
            bus.o_write_enable, bus.o_write_data_valid, bus.o_read_data_ready,
            bus.o_fifo_data, bus.o_common};
  endfunction
  function automatic logic [32:0] a_at(input int i);
    return i < alog.size() ? alog[i] : '1;
  endfunction
  function automatic logic [31:0] w_at(input int i);
    return i < wlog.size() ? wlog[i] : '1;
  endfunction
  function automatic logic [31:0] tx_word(input int i);
    return i + 3 < txq.size() ? {txq[i], txq[i+1], txq[i+2], txq[i+3]} : 32'hFFFF_FFFF;
  endfunction
  initial begin
    int t0, p0, we0, ac0, wc0, w0;
    bus.i_fifo_full = 1'b0;
    run(3);
    chk("rst_outs", outs(), 64'd0);
    reset_n = 1'b1;
    run(3);
    chk("idle_outs", outs(), 64'd0);
    feed(72'h02_00_00_10_04_DE_AD_BE_EF, 9, 0);
    run(40);
    chk("wr_addr", 64'(a_at(0)), {31'd0, 1'b1, 32'h0000_1004});
    chk("wr_data", 64'(w_at(0)), 64'hDEAD_BEEF);
    chk("wr_pops", 64'(pops), 64'd9);
`ifdef CMDCTRL_WRITE_ACK_EN
    chk("wr_ack_cnt", 64'(txq.size()), 64'd1);
    chk("wr_ack_byte", 64'(txq.size() > 0 ? txq[0] : 8'h00), 64'hA5);
`else
    chk("wr_no_tx", 64'(txq.size()), 64'd0);
`endif
    rdata = 32'h1234_5678;
    rd_delay = 3;
    we0 = we_cyc;
    t0 = txq.size();
    feed(72'h01_00_00_00_20, 5, 0);
    run(40);
    chk("rd_addr", 64'(a_at(1)), 64'h20);
    chk("rd_tx", 64'(tx_word(t0)), 64'h1234_5678);
    chk("rd_tx_cnt", 64'(txq.size() - t0), 64'd4);
    chk("rd_we_low", 64'(we_cyc - we0), 64'd0);
    addr_hold = 5;
    wdata_hold = 3;
    ac0 = a_cyc;
    wc0 = w_cyc;
    feed(72'h02_00_00_20_08_0B_AD_F0_0D, 9, 0);
    run(50);
    addr_hold = 0;
    wdata_hold = 0;
    chk("bp_addr", 64'(a_at(2)), {31'd0, 1'b1, 32'h0000_2008});
    chk("bp_data", 64'(w_at(1)), 64'h0BAD_F00D);
    chk("bp_addr_cycles", 64'(a_cyc - ac0), 64'd6);
    chk("bp_wdata_cycles", 64'(w_cyc - wc0), 64'd4);
    rdata = 32'hA1B2_C3D4;
    rd_delay = 0;
    t0 = txq.size();
    feed(72'h01_00_00_00_40, 5, 0);
    wait_tx(t0 + 1);
    bus.i_fifo_full = 1'b1;
    run(4);
    bus.i_fifo_full = 1'b0;
    run(20);
    chk("bp_rd_addr", 64'(a_at(3)), 64'h40);
    chk("bp_rd_tx", 64'(tx_word(t0)), 64'hA1B2_C3D4);
    chk("bp_rd_tx_cnt", 64'(txq.size() - t0), 64'd4);
    chk("bp_overflow", 64'(overflow), 64'd0);
    chk("bp_stability", 64'(viol), 64'd0);
    p0 = pops;
    feed(72'h02_00_00_10_04_DE_AD_BE_EF, 9, 6);
    run(30);
    chk("starve_pops", 64'(pops - p0), 64'd9);
    chk("starve_addr", 64'(a_at(4)), {31'd0, 1'b1, 32'h0000_1004});
    chk("starve_data", 64'(w_at(2)), 64'hDEAD_BEEF);
    chk("starve_underflow", 64'(underflow), 64'd0);
    rdata = 32'h55AA_33CC;
    rd_delay = 2;
    t0 = txq.size();
    p0 = pops;
    feed(72'h7F_01_00_00_00_20, 6, 0);
    run(40);
    chk("ill_addr", 64'(a_at(5)), 64'h20);
    chk("ill_addr_cnt", 64'(alog.size()), 64'd6);
    chk("ill_tx", 64'(tx_word(t0)), 64'h55AA_33CC);
    chk("ill_pops", 64'(pops - p0), 64'd6);
    w0 = wlog.size();
    feed(72'h02_00_00_10_04_DE_AD, 7, 0);
    run(30);
    chk("pre_rst_we", 64'(bus.o_write_enable), 64'd1);
    chk("pre_rst_common", 64'(bus.o_common), 64'h0000_1004);
    #2 reset_n = 1'b0;
    #1 chk("mid_rst_outs", outs(), 64'd0);
    @(negedge clk);
    reset_n = 1'b1;
    run(3);
    chk("post_rst_outs", outs(), 64'd0);
    rdata = 32'hCAFE_F00D;
    rd_delay = 1;
    t0 = txq.size();
    feed(72'h01_00_00_00_24, 5, 0);
    run(40);
    chk("rst_rd_addr", 64'(a_at(7)), 64'h24);
    chk("rst_rd_tx", 64'(tx_word(t0)), 64'hCAFE_F00D);
    chk("rst_no_wdata", 64'(wlog.size()), 64'(w0));
    chk("final_stability", 64'(viol), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/cmd_bus_bridge.md
Name: cmd_bus_bridge

Overview:
- Bridges a byte-wide host command stream to a 32-bit valid/ready register interconnect.
- Pops command/address/data bytes from the host-to-device byte FIFO and decodes read/write commands.
- Runs the corresponding bus transaction.
- Pushes read data, and optionally write acknowledges, into the device-to-host byte FIFO.
- Sits between the FT2232H-side FIFOs and the shell interconnect master port.

Parameters:
- WORD_WIDTH, 32, interconnect address/data width in bits; fixed at 32 (4 bytes).
- CMD_READ, 8'h01, command byte for a single-word read.
- CMD_WRITE, 8'h02, command byte for a single-word write.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  reset.
- i_fifo_data  in  8  RX FIFO read data; valid the cycle after a pop.
- i_fifo_empty  in  1  RX FIFO empty.
- i_fifo_almost_empty  in  1  RX FIFO holds at most 1 entry.
- o_fifo_read_enable  out  1  RX FIFO pop.
- o_fifo_data  out  8  TX FIFO write data.
- i_fifo_full  in  1  TX FIFO full.
- o_fifo_write_enable  out  1  TX FIFO push.
- o_addr_valid  out  1  address phase valid.
- o_write_enable  out  1  1 = write transaction, 0 = read; held for the whole transaction.
- o_write_data_valid  out  1  write data phase valid.
- i_addr_ready  in  1  address accepted.
- i_write_data_ready  in  1  write data accepted.
- i_read_data_valid  in  1  read data valid.
- o_read_data_ready  out  1  bridge ready for read data.
- o_common  out  32  shared address / write-data bus.
- i_read_data  in  32  read data.

Interface rules:
- One clock; reset is asynchronous and active-low.
- Clock port is clk; reset port is reset_n.

Behaviour:
- Reset: all outputs 0; state IDLE. Reset mid-transaction aborts it; partially received bytes are discarded.
- RX pop rules (registered-read FIFO, data one cycle after pop):
  - Pop only when !i_fifo_empty.
  - Back-to-back pops allowed only while !i_fifo_almost_empty.
  - Otherwise pop one byte, then re-evaluate empty.
- States:
  - IDLE: pop command byte.
    - CMD_READ → GET_ADDR.
    - CMD_WRITE → GET_ADDR.
    - Any other byte is silently dropped; stay IDLE.
  - GET_ADDR: collect 4 bytes, MSB first, into the address register → ADDR_PHASE.
  - ADDR_PHASE: o_common = address; o_addr_valid=1; o_write_enable = (cmd==WRITE).
    - Hold until i_addr_ready is sampled 1 while valid=1; then drop valid.
    - On handshake: write → GET_WDATA; read → RDATA_PHASE.
  - GET_WDATA: collect 4 data bytes, MSB first → WDATA_PHASE.
  - WDATA_PHASE: o_common = data; o_write_data_valid=1.
    - Hold until i_write_data_ready.
    - Then → ACK if CMDCTRL_WRITE_ACK_EN is defined, else → IDLE.
  - RDATA_PHASE: o_read_data_ready=1. On i_read_data_valid, capture i_read_data → PUSH_RDATA.
  - PUSH_RDATA: push 4 bytes, MSB first, one per cycle, only in cycles where !i_fifo_full; stall otherwise → IDLE.
- o_common holds its last value when no valid is asserted; o_write_enable returns to 0 in IDLE.
- Valid signals never drop before their handshake. Ready/valid sampled in the same cycle completes the handshake, with zero wait states allowed.
- Bus address phase never starts before all 4 address bytes are received; write data phase never starts before all 4 data bytes are received.
- A new command byte is popped only in IDLE; there is no pipelining.

Optional Feature:
- Macro CMDCTRL_WRITE_ACK_EN.
- Defined: after the write data handshake, enter ACK state and push one byte 8'hA5 to the TX FIFO (stall while full), then → IDLE.
- Undefined: no ACK state and no TX traffic on writes.

Test Plan:
- Write: RX bytes 02,00,00,10,04,DE,AD,BE,EF; slave ready immediately → o_addr_valid with o_common=32'h00001004, o_write_enable=1; then o_write_data_valid with o_common=32'hDEADBEEF; no TX push (or exactly one 8'hA5 when CMDCTRL_WRITE_ACK_EN is defined).
- Read: RX 01,00,00,00,20; i_read_data=32'h12345678 valid 3 cycles after address handshake → TX receives 12,34,56,78 in order; o_write_enable=0 throughout.
- Backpressure: hold i_addr_ready=0 for 5 cycles, i_write_data_ready=0 for 3 cycles, i_fifo_full=1 for 4 cycles mid-push → valids stay high and o_common is stable; no byte is lost or duplicated.
- Starved RX: feed write command bytes one every 6 cycles (almost_empty/empty toggling) → exactly 9 pops; transaction identical to the write case above.
- Illegal command: RX 7F followed by a valid read command → 7F dropped; read executes normally.
- Reset: assert reset_n=0 during GET_WDATA → all outputs 0 immediately; after release, a fresh read command completes correctly.
